imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
// - Writer side of the CPU instruction memory. The CPU core fetches 18-bit words from it; this block fills it.
// - Receives a byte stream over a valid/ready handshake and packs each 3 bytes into one 18-bit instruction.
// - Writes the words to consecutive addresses starting at 0.
// - Holds the CPU (cpu_hold) until a complete image is loaded. This replaces the fixed boot-time image.
// PARAMETERS
// - AW  16  instruction address width; matches the 16-bit PC
// - DW  18  instruction word width; only 18 is supported (3-byte packing)
// PORTS
// - clk       in   1   system clock; all logic on posedge
// - reset_n   in   1   synchronous, active-low reset
// - start     in   1   one-cycle pulse: begin a load
// - in_data   in   8   stream byte
// - in_valid  in   1   in_data valid
// - in_ready  out  1   loader accepts in_data this cycle
// - wr_en     out  1   instruction-memory write strobe
// - wr_addr   out  AW  write address
// - wr_data   out  DW  write data
// - cpu_hold  out  1   1 = CPU PC held/stalled
// - busy      out  1   load in progress
// - done      out  1   sticky: last load completed OK
// - error     out  1   sticky: last load aborted
// BEHAVIOUR
// - Reset (reset_n=0 at posedge): state=IDLE; in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, error=0, cpu_hold=1.
// - Transfer: a byte transfers on a posedge with in_valid & in_ready. in_ready is combinational from state only (never from in_valid).
// - Frame layout:
//   - LEN_HI, LEN_LO: word count N, big-endian 16 bits.
//   - Then N words, 3 bytes each:
//     - B0[1:0] = instr[17:16]; B0[7:2] ignored.
//     - B1 = instr[15:8].
//     - B2 = instr[7:0].
// - FSM states: IDLE, LEN_HI, LEN_LO, B0, B1, B2, WRITE, CHK, DONE, ERR.
//   - IDLE/DONE/ERR --start--> LEN_HI. This clears done, clears error, sets busy=1 and cpu_hold=1.
//   - start is ignored in every other state.
//   - LEN_HI -> LEN_LO -> (N==0 ? end : B0). Each step advances on a transfer.
//   - N > 2**AW: go to ERR after LEN_LO.
//   - B0 -> B1 -> B2 -> WRITE, advancing on transfers. in_ready=1 only in LEN_HI, LEN_LO, B0, B1, B2, CHK.
//   - WRITE (1 cycle, in_ready=0):
//     - wr_en=1, wr_addr=word index, wr_data=packed word.
//     - Next state: B0 if more words remain, else end.
//   - Write latency: wr_en asserts exactly 1 cycle after the B2 transfer.
//   - "end": CHK if IMEM_LOADER_CHKSUM_EN, else DONE.
//   - DONE: busy=0, done=1, cpu_hold=0.
//   - ERR: busy=0, error=1, cpu_hold=1.
// - wr_addr: the word index counts 0..N-1 and never wraps. The N > 2**AW check guarantees this.
// - Stalls: in_valid low for any number of cycles stalls the FSM. No timeout.
// - wr_en is 0 in every state except WRITE. wr_addr/wr_data hold their last values.
// - Reset mid-load: returns to the reset state. Words already written stay in memory. done=0, so the CPU stays held.
// - Simultaneous start & reset_n=0: reset wins.
// CONFIGURATION
// - IMEM_LOADER_CHKSUM_EN defined:
//   - After the last WRITE, or after LEN_LO when N==0, one extra byte is accepted in CHK.
//   - Checksum = 8-bit mod-256 sum of all preceding frame bytes, including both length bytes.
//   - Match -> DONE. Mismatch -> ERR.
// - Undefined: no CHK state. The end of the frame goes straight to DONE and no trailing byte is consumed.
// TESTING
// - Reset: hold reset_n=0 for 2 cycles -> cpu_hold=1, busy=0, done=0, error=0, wr_en=0, in_ready=0.
// - Basic load, no stalls: start, then bytes 00 02 | 03 12 34 | 00 00 01.
//   - Writes: addr0=18'h31234, addr1=18'h00001.
//   - done=1 and cpu_hold=0 two cycles after the final byte.
// - Backpressure and ignored bits:
//   - Toggle in_valid randomly during a 3-word load; B0=FD -> instr[17:16]=2'b01.
//   - Exactly 3 wr_en pulses; in_ready=0 in each WRITE cycle.
// - Edge counts:
//   - N=0 -> DONE with no wr_en.
//   - AW=4 build with N=17 -> ERR after LEN_LO, cpu_hold stays 1.
//   - start pulsed mid-load is ignored.
// - Reset mid-load: assert reset_n=0 after word 1 of 3 -> all outputs at reset values. A following start reloads from addr 0.
// - CHKSUM_EN:
//   - Frame 00 01 00 00 05 + checksum 06 -> done=1.
//   - Same frame with checksum 07 -> error=1, done=0.

Source files
------------

// File: rtl/imem_loader_if.sv
// Loader bus: byte stream in, instruction-memory write port and CPU status out.
// A byte moves on a rising clk edge where in_valid && in_ready; in_ready depends only on loader state.
interface imem_loader_if #(
  parameter int AW = 16,
  parameter int DW = 18
);
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          error;

  modport master (
    output start, in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, error
  );

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a length-prefixed byte stream into 18-bit words and holds the CPU until done.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CHKSUM_EN.
module imem_loader #(
  parameter int AW = 16,
  parameter int DW = 18
) (
  input  logic       clk,
  input  logic       reset_n,
  imem_loader_if.slave bus,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LEN_HI = 4'd1,
    LEN_LO = 4'd2,
    B0     = 4'd3,
    B1     = 4'd4,
    B2     = 4'd5,
    WRITE  = 4'd6,
`ifdef IMEM_LOADER_CHKSUM_EN
    CHK    = 4'd7,
`endif
    DONE   = 4'd8,
    ERR    = 4'd9
  } state_t;

`ifdef IMEM_LOADER_CHKSUM_EN
  localparam state_t END_ST = CHK;
  logic [7:0]    sum_q;
`else
  localparam state_t END_ST = DONE;
`endif

  state_t        state, state_nxt;
  logic          in_ready;
  logic          xfer;
  logic [7:0]    len_hi_q;
  logic [15:0]   n_q;
  logic [15:0]   n_now;
  logic [1:0]    b0_q;
  logic [7:0]    b1_q;
  logic [AW-1:0] word_idx;
  logic          more_words;
  logic          too_long;

  assign in_ready   = (state == LEN_HI) || (state == LEN_LO) || (state == B0) ||
`ifdef IMEM_LOADER_CHKSUM_EN
                      (state == CHK) ||
`endif
                      (state == B1) || (state == B2);
  assign bus.in_ready = in_ready;
  assign xfer       = bus.in_valid && in_ready;
  assign n_now      = {len_hi_q, bus.in_data};
  // N may equal 2**AW exactly; the last index 2**AW-1 still fits in AW bits.
  assign too_long   = 32'(n_now) > (32'd1 << AW);
  assign more_words = (32'(word_idx) + 32'd1) < 32'(n_q);
  assign state_dbg  = state;

  always_comb begin
    state_nxt    = state;
    bus.wr_en    = 1'b0;
    bus.busy     = 1'b1;
    bus.done     = 1'b0;
    bus.error    = 1'b0;
    bus.cpu_hold = 1'b1;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_nxt = LEN_HI;
      end
      LEN_HI: if (xfer) state_nxt = LEN_LO;
      LEN_LO: begin
        if (xfer) begin
          if (too_long)           state_nxt = ERR;
          else if (n_now == '0)   state_nxt = END_ST;
          else                    state_nxt = B0;
        end
      end
      B0: if (xfer) state_nxt = B1;
      B1: if (xfer) state_nxt = B2;
      B2: if (xfer) state_nxt = WRITE;
      WRITE: begin
        bus.wr_en = 1'b1;
        state_nxt = more_words ? B0 : END_ST;
      end
`ifdef IMEM_LOADER_CHKSUM_EN
      CHK: if (xfer) state_nxt = (bus.in_data == sum_q) ? DONE : ERR;
`endif
      DONE: begin
        bus.busy     = 1'b0;
        bus.done     = 1'b1;
        bus.cpu_hold = 1'b0;
        if (bus.start) state_nxt = LEN_HI;
      end
      ERR: begin
        bus.busy  = 1'b0;
        bus.error = 1'b1;
        if (bus.start) state_nxt = LEN_HI;
      end
      default: begin
        bus.busy  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      len_hi_q    <= '0;
      n_q         <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      word_idx    <= '0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
`ifdef IMEM_LOADER_CHKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (bus.start && (state == IDLE || state == DONE || state == ERR)) begin
        word_idx <= '0;
`ifdef IMEM_LOADER_CHKSUM_EN
        sum_q    <= '0;
`endif
      end
      if (xfer) begin
`ifdef IMEM_LOADER_CHKSUM_EN
        if (state != CHK) sum_q <= sum_q + bus.in_data;
`endif
        case (state)
          LEN_HI: len_hi_q <= bus.in_data;
          LEN_LO: n_q      <= n_now;
          B0:     b0_q     <= bus.in_data[1:0];
          B1:     b1_q     <= bus.in_data;
          B2: begin
            bus.wr_addr <= word_idx;
            bus.wr_data <= {b0_q, b1_q, bus.in_data};
          end
          default: ;
        endcase
      end
      if (state == WRITE) word_idx <= word_idx + AW'(1);
    end
  end

endmodule
